// File: rtl/mem_slot_sched_pkg.sv
// Shared types and constants for the memory-slot scheduler.
package mem_slot_pkg;

  typedef enum logic [2:0] {
    OWN_IDLE,
    OWN_VID,
    OWN_REF,
    OWN_DSP,
    OWN_BLT,
    OWN_CPU
  } slot_owner_e;

  typedef logic [1:0] slot_phase_t;

  localparam slot_phase_t PH_START  = 2'd0;
  localparam slot_phase_t PH_MID    = 2'd1;
  localparam slot_phase_t PH_DECIDE = 2'd2;

  // Round-robin indices, also the bit positions in the rr request vector
  localparam logic [1:0] RR_DSP = 2'd0;
  localparam logic [1:0] RR_BLT = 2'd1;
  localparam logic [1:0] RR_CPU = 2'd2;

  // Next round-robin index, wrapping 2 -> 0
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == RR_CPU) ? RR_DSP : idx + 2'd1;
  endfunction

endpackage

// File: rtl/mem_slot_sched_rr3_pick.sv
// Combinational 3-way round-robin picker: first requester found searching
// from ptr_i upward (cyclically) wins; one-hot result, zero if no request.
module rr3_pick (
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] pick_o
);

  logic [2:0] rot;
  logic [2:0] sel;

  // Rotate so the favoured requester sits in bit 0, fixed-priority select, rotate back
  always_comb begin
    case (ptr_i)
      2'd1:    rot = {req_i[0], req_i[2], req_i[1]};
      2'd2:    rot = {req_i[1], req_i[0], req_i[2]};
      default: rot = req_i;
    endcase

    sel = '0;
    if (rot[0])      sel = 3'b001;
    else if (rot[1]) sel = 3'b010;
    else if (rot[2]) sel = 3'b100;

    case (ptr_i)
      2'd1:    pick_o = {sel[1], sel[0], sel[2]};
      2'd2:    pick_o = {sel[0], sel[2], sel[1]};
      default: pick_o = sel;
    endcase
  end

endmodule

// File: rtl/mem_slot_sched.sv
// Memory-slot scheduler: divides MCK into 3-tick slots and hands each slot
// to video, refresh, or a round-robin choice among DSP/blitter/CPU.
import mem_slot_pkg::*;

module mem_slot_sched #(
  parameter int unsigned REFPER   = 64,
  parameter int unsigned MAXBURST = 4
) (
  input  logic       MCK,
  input  logic       RESET,
  input  logic       VIDREQ,
  input  logic       DSPREQ,
  input  logic       BLTREQ,
  input  logic       CPUREQ,
  output logic [1:0] PHASE,
  output logic       SLOTSTART,
  output logic       VIDGNT,
  output logic       REFGNT,
  output logic       DSPGNT,
  output logic       BLTGNT,
  output logic       CPUGNT,
  output logic       REFOVF
);

  localparam int unsigned CW = (REFPER > 2) ? $clog2(REFPER) : 1;
  localparam int unsigned BW = $clog2(MAXBURST + 1);

  slot_phase_t   phase_q, phase_d;
  slot_owner_e   owner_q, owner_d;
  logic [CW-1:0] refcnt_q, refcnt_d;
  logic          refpend_q, refpend_d;
  logic          refovf_q, refovf_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [BW-1:0] burst_q, burst_d;

  logic [2:0]    rr_req;
  logic [2:0]    rr_pick;
  logic [1:0]    pick_idx;
  logic [1:0]    eff_ptr;
  logic          rotate;

  assign rr_req = {CPUREQ, BLTREQ, DSPREQ};

  // Force the pointer past a favoured owner that used up its burst while others wait
  always_comb begin
    rotate  = (32'(burst_q) >= MAXBURST) && ((rr_req & ~(3'b001 << ptr_q)) != 3'b000);
    eff_ptr = rotate ? rr_next(ptr_q) : ptr_q;
  end

  rr3_pick u_pick (
    .req_i  (rr_req),
    .ptr_i  (eff_ptr),
    .pick_o (rr_pick)
  );

  // Slot arbitration and refresh bookkeeping, evaluated in the decide phase
  always_comb begin
    phase_d   = (phase_q == PH_DECIDE) ? PH_START : phase_q + 2'd1;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    burst_d   = burst_q;
    refcnt_d  = refcnt_q;
    refpend_d = refpend_q;
    refovf_d  = refovf_q;
    pick_idx  = rr_pick[1] ? RR_BLT : (rr_pick[2] ? RR_CPU : RR_DSP);

    if (phase_q == PH_DECIDE) begin
      if (VIDREQ) begin
        owner_d = OWN_VID;
      end else if (refpend_q) begin
        owner_d = OWN_REF;
      end else if (rr_pick == 3'b000) begin
        owner_d = OWN_IDLE;
        burst_d = '0;
      end else begin
        owner_d = rr_pick[0] ? OWN_DSP : (rr_pick[1] ? OWN_BLT : OWN_CPU);
        if (!rotate && pick_idx == ptr_q) begin
          if (32'(burst_q) < MAXBURST) burst_d = burst_q + BW'(1);
        end else begin
          ptr_d   = pick_idx;
          burst_d = BW'(1);
        end
      end

      // A refresh slot issued on the same edge as a new request consumes the old one
      if (refcnt_q == '0) begin
        refcnt_d  = CW'(REFPER - 1);
        refpend_d = 1'b1;
        if (refpend_q && owner_d != OWN_REF) refovf_d = 1'b1;
      end else begin
        refcnt_d = refcnt_q - CW'(1);
        if (owner_d == OWN_REF) refpend_d = 1'b0;
      end
    end
  end

  // State registers; reset parks in the decide phase so the first edge starts a slot
  always_ff @(posedge MCK or posedge RESET) begin
    if (RESET) begin
      phase_q   <= PH_DECIDE;
      owner_q   <= OWN_IDLE;
      refcnt_q  <= CW'(REFPER - 1);
      refpend_q <= 1'b0;
      refovf_q  <= 1'b0;
      ptr_q     <= RR_DSP;
      burst_q   <= '0;
    end else begin
      phase_q   <= phase_d;
      owner_q   <= owner_d;
      refcnt_q  <= refcnt_d;
      refpend_q <= refpend_d;
      refovf_q  <= refovf_d;
      ptr_q     <= ptr_d;
      burst_q   <= burst_d;
    end
  end

  assign PHASE     = phase_q;
  assign SLOTSTART = (phase_q == PH_START);
  assign VIDGNT    = (owner_q == OWN_VID);
  assign REFGNT    = (owner_q == OWN_REF);
  assign DSPGNT    = (owner_q == OWN_DSP);
  assign BLTGNT    = (owner_q == OWN_BLT);
  assign CPUGNT    = (owner_q == OWN_CPU);
  assign REFOVF    = refovf_q;

endmodule

// File: tb/tb_mem_slot_sched.sv
// Self-checking bench for mem_slot_sched: slot-level behavioural model plus
// directed scenarios with hand-computed expectations.
module tb_mem_slot_sched;

  localparam int REFPER   = 64;
  localparam int MAXBURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vid = 1'b0, dsp = 1'b0, blt = 1'b0, cpu = 1'b0;
  logic [1:0] PHASE;
  logic SLOTSTART, VIDGNT, REFGNT, DSPGNT, BLTGNT, CPUGNT, REFOVF;

  int total = 0;
  int bad   = 0;

  mem_slot_sched #(.REFPER(REFPER), .MAXBURST(MAXBURST)) dut (
    .MCK(clk), .RESET(rst), .VIDREQ(vid), .DSPREQ(dsp), .BLTREQ(blt), .CPUREQ(cpu),
    .PHASE(PHASE), .SLOTSTART(SLOTSTART), .VIDGNT(VIDGNT), .REFGNT(REFGNT),
    .DSPGNT(DSPGNT), .BLTGNT(BLTGNT), .CPUGNT(CPUGNT), .REFOVF(REFOVF)
  );

  initial forever #5 clk = ~clk;

  // ---------------- slot-level model ----------------
  // owner codes: 0 idle, 1 vid, 2 ref, 3 dsp, 4 blt, 5 cpu
  int m_phase = 2, m_slot = -1, m_owner = 0;
  int m_slots_to_req = REFPER;   // slot starts until the next refresh request
  bit m_pend = 0, m_ovf = 0;
  int m_fav = 0, m_run = 0;      // favoured rr owner (0 dsp,1 blt,2 cpu), consecutive slots

  task automatic model_reset();
    m_phase = 2; m_slot = -1; m_owner = 0; m_slots_to_req = REFPER;
    m_pend = 0; m_ovf = 0; m_fav = 0; m_run = 0;
  endtask

  task automatic model_step();
    bit rq[3];
    int start, pick;
    bit others;
    if (m_phase != 2) begin
      m_phase++;
      return;
    end
    rq = '{dsp, blt, cpu};
    m_phase = 0;
    m_slot++;
    if (vid) m_owner = 1;
    else if (m_pend) m_owner = 2;
    else begin
      others = 0;
      for (int k = 0; k < 3; k++) if (k != m_fav && rq[k]) others = 1;
      start = (m_run >= MAXBURST && others) ? (m_fav + 1) % 3 : m_fav;
      pick = -1;
      for (int k = 0; k < 3; k++) if (pick < 0 && rq[(start + k) % 3]) pick = (start + k) % 3;
      if (pick < 0) begin
        m_owner = 0; m_run = 0;
      end else begin
        m_owner = 3 + pick;
        if (pick == m_fav && start == m_fav) begin
          if (m_run < MAXBURST) m_run++;
        end else begin
          m_fav = pick; m_run = 1;
        end
      end
    end
    // refresh request issued every REFPER slot starts, first at the REFPER-th
    m_slots_to_req--;
    if (m_slots_to_req == 0) begin
      m_slots_to_req = REFPER;
      if (m_pend && m_owner != 2) m_ovf = 1;
      m_pend = 1;
    end else if (m_owner == 2) begin
      m_pend = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset(); else model_step();
  end

  function automatic logic [8:0] model_vec();
    logic [1:0] ph;
    ph = 2'(m_phase);
    return {ph, m_phase == 0, m_owner == 1, m_owner == 2, m_owner == 3,
            m_owner == 4, m_owner == 5, m_ovf};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {PHASE, SLOTSTART, VIDGNT, REFGNT, DSPGNT, BLTGNT, CPUGNT, REFOVF};
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model
  initial forever begin
    @(negedge clk);
    chk("cycle", dut_vec(), model_vec());
  end

  // Advance to the negedge where the model is in slot s, phase p
  task automatic wait_at(input int s, input int p);
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (m_slot == s && m_phase == p) return;
    end
    total++; bad++;
    $display("FAIL wait_at: slot %0d phase %0d not reached (at slot %0d)", s, p, m_slot);
  endtask

  task automatic do_reset(input logic v, input logic d, input logic b, input logic c);
    #1;
    rst = 1'b1; vid = v; dsp = d; blt = b; cpu = c;
    @(negedge clk);
    chk("reset_state", dut_vec(), 9'b10_0_00000_0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // 1: no requests, refresh cadence
    do_reset(0, 0, 0, 0);
    wait_at(0, 0);   chk("t1_first_phase", {7'd0, PHASE}, 9'd0);
    wait_at(63, 1);  chk("t1_ref63", {8'd0, REFGNT}, 9'd0);
    wait_at(64, 1);  chk("t1_ref64", {8'd0, REFGNT}, 9'd1);
    wait_at(65, 1);  chk("t1_ref65", {8'd0, REFGNT}, 9'd0);
    wait_at(128, 1); chk("t1_ref128", {8'd0, REFGNT}, 9'd1);

    // 2: three rr requesters, bursts of MAXBURST
    do_reset(0, 1, 1, 1);
    for (int s = 0; s < 16; s++) begin
      logic [2:0] want;
      wait_at(s, 1);
      want = 3'b001 << ((s / 4) % 3);
      chk("t2_rr_order", {6'd0, CPUGNT, BLTGNT, DSPGNT}, {6'd0, want});
    end

    // 3: lone blitter keeps the bus, video preempts for one slot
    do_reset(0, 0, 1, 0);
    wait_at(5, 1);  chk("t3_blt_past_burst", {8'd0, BLTGNT}, 9'd1);
    wait_at(9, 2);  vid = 1'b1;
    wait_at(10, 0); chk("t3_vid", {7'd0, VIDGNT, BLTGNT}, 9'b10);
    vid = 1'b0;
    wait_at(11, 0); chk("t3_blt_resume", {7'd0, VIDGNT, BLTGNT}, 9'b01);

    // 4: video starves refresh
    do_reset(1, 0, 0, 0);
    wait_at(64, 1);  chk("t4_no_ref", {7'd0, VIDGNT, REFGNT}, 9'b10);
    wait_at(126, 1); chk("t4_ovf_clear", {8'd0, REFOVF}, 9'd0);
    wait_at(127, 0); vid = 1'b0;
    wait_at(128, 1); chk("t4_ref_after", {7'd0, REFGNT, REFOVF}, 9'b11);
    wait_at(129, 1); chk("t4_idle_after", {3'd0, VIDGNT, REFGNT, DSPGNT, BLTGNT, CPUGNT, REFOVF}, 9'b1);

    // 5: CPU drops mid-slot, DSP waiting
    do_reset(0, 0, 0, 1);
    wait_at(0, 0); cpu = 1'b0; dsp = 1'b1;
    wait_at(0, 2); chk("t5_cpu_holds", {8'd0, CPUGNT}, 9'd1);
    wait_at(1, 0); chk("t5_dsp_next", {7'd0, DSPGNT, CPUGNT}, 9'b10);

    // 6: asynchronous reset in a DSP slot
    wait_at(2, 1);
    #1 rst = 1'b1;
    #1 chk("t6_async_drop", {6'd0, PHASE, DSPGNT}, 9'b100);
    blt = 1'b1; cpu = 1'b1;
    #1 rst = 1'b0;
    wait_at(0, 0); chk("t6_restart", {6'd0, PHASE, DSPGNT}, 9'b001);
    wait_at(3, 1); chk("t6_dsp_full_burst", {8'd0, DSPGNT}, 9'd1);
    wait_at(4, 1); chk("t6_blt_after", {8'd0, BLTGNT}, 9'd1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
